// File: rtl/ycbcr_pkg.sv
// Shared constants and types for the YCbCr block path.
// Holds the Q16.16 format, component codes and the serializer state encoding.
package ycbcr_pkg;

   localparam int unsigned FIXED_POINT_LENGTH = 32;
   localparam int unsigned Q_FRAC_BITS        = 16;
   localparam int unsigned Q_INT_BITS         = FIXED_POINT_LENGTH - Q_FRAC_BITS;
   localparam int unsigned Q_ONE              = 1 << Q_FRAC_BITS;
   localparam int unsigned Q_HALF             = 1 << (Q_FRAC_BITS - 1);
   localparam int unsigned BLOCK_PIXELS       = 64;
   localparam int unsigned S8_WIDTH           = 8;

   localparam int          LEVEL_SHIFT        = 128;

   localparam logic [1:0]  COMP_Y             = 2'd0;
   localparam logic [1:0]  COMP_CB            = 2'd1;
   localparam logic [1:0]  COMP_CR            = 2'd2;

   typedef enum logic [1:0] {
      StIdle,
      StSendY,
      StSendCb,
      StSendCr
   } ser_state_t;

endpackage

// File: rtl/q16_to_s8_level_shift.sv
// Signed fixed-point sample to saturated, level-shifted signed byte.
// Rounds half up via add-then-arithmetic-shift, subtracts LEVEL_SHIFT, clamps.
module q16_to_s8_level_shift
   import ycbcr_pkg::*;
#(
   parameter int unsigned IN_WIDTH  = 32,
   parameter int unsigned FRAC_BITS = 16,
   parameter int unsigned OUT_WIDTH = 8
) (
   input  logic signed [IN_WIDTH-1:0]  i_sample,
   output logic signed [OUT_WIDTH-1:0] o_data
);

   // Two guard bits keep the rounding add and level shift overflow-free.
   localparam int unsigned IW = IN_WIDTH + 2;
   localparam logic signed [IW-1:0] HALF  = IW'(1) << (FRAC_BITS - 1);
   localparam logic signed [IW-1:0] SHIFT = IW'(LEVEL_SHIFT);
   localparam logic signed [IW-1:0] MAX_V = IW'((1 << (OUT_WIDTH - 1)) - 1);
   localparam logic signed [IW-1:0] MIN_V = ~MAX_V;

   logic signed [IW-1:0] w_ext;
   logic signed [IW-1:0] w_round;
   logic signed [IW-1:0] w_shift;
   logic signed [IW-1:0] w_level;

   assign w_ext   = {{2{i_sample[IN_WIDTH-1]}}, i_sample};
   assign w_round = w_ext + HALF;
   assign w_shift = w_round >>> FRAC_BITS;
   assign w_level = w_shift - SHIFT;

   always_comb begin
      o_data = w_level[OUT_WIDTH-1:0];
      if (w_level > MAX_V) begin
         o_data = MAX_V[OUT_WIDTH-1:0];
      end else if (w_level < MIN_V) begin
         o_data = MIN_V[OUT_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/ycbcr_block_serializer.sv
// Captures one Y/Cb/Cr block and streams it as 192 signed bytes, Y then Cb then Cr.
// All outputs derive from registered state; out_data passes through one converter.
module ycbcr_block_serializer
   import ycbcr_pkg::*;
#(
   parameter int unsigned fixed_point_length = 32,
   parameter int unsigned FRAC_BITS          = 16,
   parameter int unsigned PIXEL_COUNT        = 64,
   parameter int unsigned OUT_WIDTH          = 8
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       in_valid,
   input  logic [PIXEL_COUNT*fixed_point_length-1:0]  y_all,
   input  logic [PIXEL_COUNT*fixed_point_length-1:0]  cb_all,
   input  logic [PIXEL_COUNT*fixed_point_length-1:0]  cr_all,
   output logic                                       in_ready,
   output logic signed [OUT_WIDTH-1:0]                out_data,
   output logic [1:0]                                 out_comp,
   output logic [$clog2(PIXEL_COUNT)-1:0]             out_index,
   output logic                                       out_last,
   output logic                                       out_valid,
   input  logic                                       out_ready,
   output logic                                       block_done
);

   localparam int unsigned VEC_W = PIXEL_COUNT * fixed_point_length;
   localparam int unsigned IDX_W = $clog2(PIXEL_COUNT);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXEL_COUNT - 1);

   ser_state_t                     r_state, w_state_next;
   logic [IDX_W-1:0]               r_index, w_index_next;
   logic [VEC_W-1:0]               r_y, r_cb, r_cr;
   logic                           r_done, w_done_next;
   logic                           w_capture;
   logic                           w_idx_last;
   logic [fixed_point_length-1:0]  w_sample;
   logic signed [OUT_WIDTH-1:0]    w_conv;

   assign w_idx_last = (r_index == LAST_IDX);

   always_comb begin
      w_state_next = r_state;
      w_index_next = r_index;
      w_done_next  = 1'b0;
      w_capture    = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (in_valid) begin
               w_capture    = 1'b1;
               w_state_next = StSendY;
               w_index_next = '0;
            end
         end
         StSendY, StSendCb, StSendCr: begin
            if (out_ready) begin
               w_index_next = r_index + 1'b1;
               if (w_idx_last) begin
                  w_index_next = '0;
                  unique case (r_state)
                     StSendY:  w_state_next = StSendCb;
                     StSendCb: w_state_next = StSendCr;
                     default: begin
                        w_state_next = StIdle;
                        w_done_next  = 1'b1;
                     end
                  endcase
               end
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= StIdle;
         r_index <= '0;
         r_done  <= 1'b0;
         r_y     <= '0;
         r_cb    <= '0;
         r_cr    <= '0;
      end else begin
         r_state <= w_state_next;
         r_index <= w_index_next;
         r_done  <= w_done_next;
         if (w_capture) begin
            r_y  <= y_all;
            r_cb <= cb_all;
            r_cr <= cr_all;
         end
      end
   end

   always_comb begin
      w_sample = '0;
      out_comp = COMP_Y;
      unique case (r_state)
         StSendY: begin
            w_sample = r_y[int'(r_index)*fixed_point_length +: fixed_point_length];
            out_comp = COMP_Y;
         end
         StSendCb: begin
            w_sample = r_cb[int'(r_index)*fixed_point_length +: fixed_point_length];
            out_comp = COMP_CB;
         end
         StSendCr: begin
            w_sample = r_cr[int'(r_index)*fixed_point_length +: fixed_point_length];
            out_comp = COMP_CR;
         end
         default: begin
            w_sample = '0;
            out_comp = COMP_Y;
         end
      endcase
   end

   q16_to_s8_level_shift #(
      .IN_WIDTH  (fixed_point_length),
      .FRAC_BITS (FRAC_BITS),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_conv (
      .i_sample (w_sample),
      .o_data   (w_conv)
   );

   assign out_valid  = (r_state != StIdle);
   assign in_ready   = (r_state == StIdle);
   // Idle still drives the converter from cleared registers, so force zero there.
   assign out_data   = out_valid ? w_conv : '0;
   assign out_index  = r_index;
   assign out_last   = (r_state == StSendCr) && w_idx_last;
   assign block_done = r_done;

endmodule
